serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit Full_Adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, through a DIGIT-bit ripple chain of full-adder cells.
- Holds the carry in a register between digits.
- Valid/ready handshakes on the input and output sides let it sit between a request source and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits added per clock cycle; 1 ≤ DIGIT ≤ WIDTH.
- Derived constant NSTEP = WIDTH/DIGIT: number of compute cycles.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START_VALID  input  1  operands presented.
- START_READY  output  1  block can accept operands.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- CARRY_IN  input  1  initial carry.
- DONE_VALID  output  1  result available.
- DONE_READY  input  1  consumer accepts the result.
- SUM  output  WIDTH  X+Y+CARRY_IN, modulo 2^WIDTH.
- CARRY_OUT  output  1  carry out of bit WIDTH-1.
- OVERFLOW  output  1  two's-complement overflow (carry into MSB xor carry out of MSB).

Behaviour:
- Reset (async, any state, including mid-computation):
  - state=IDLE, step counter=0, carry register=0, operand and sum shift registers=0.
  - Outputs: SUM=0, CARRY_OUT=0, OVERFLOW=0, DONE_VALID=0, START_READY=1 (combinational from IDLE, so high while RST is asserted).
  - An in-flight operation is discarded silently.
- States: IDLE, RUN, DONE.
- IDLE:
  - START_READY=1, DONE_VALID=0.
  - On an edge with START_VALID=1: latch X, Y into the operand shift registers, latch CARRY_IN into the carry register, clear the step counter, go to RUN.
- RUN:
  - START_READY=0.
  - Each edge: add the low DIGIT bits of both operand registers plus the carry register.
  - Shift the DIGIT-bit result into the top of the sum register, shift both operand registers right by DIGIT, update the carry register, increment the counter.
  - On the final digit (counter=NSTEP-1): capture CARRY_OUT (chain carry out), capture OVERFLOW (carry into top cell xor carry out of top cell), go to DONE.
  - X, Y, CARRY_IN and START_VALID are ignored in RUN.
- DONE:
  - DONE_VALID=1, START_READY=0.
  - SUM, CARRY_OUT, OVERFLOW are held stable until an edge with DONE_READY=1, then the block goes to IDLE.
  - START_VALID in the same cycle is not accepted. There is no back-to-back issue; the minimum initiation interval is NSTEP+2 cycles.
- Latency: handshake at edge k → DONE_VALID high after edge k+NSTEP.
- SUM is meaningful only while DONE_VALID=1; during RUN it shows the partial shift contents.
- WIDTH=DIGIT: NSTEP=1, a single RUN cycle.
- Carry register width is 1 bit. Arithmetic wraps modulo 2^WIDTH, with the carry reported only on CARRY_OUT.

Decomposition:
- Package serial_adder_pkg:
  - state enum {IDLE, RUN, DONE}.
  - helper function for counter width, $clog2(NSTEP) with a minimum of 1.
- Sub-module full_adder_chain, parameter DIGIT:
  - Combinational ripple of DIGIT full-adder cells.
  - Ports: A, B [DIGIT], CI → S [DIGIT], CO, C_MSB (carry into the top cell, used for OVERFLOW).
  - Instanced once per serial_adder.
- The top level holds the FSM, counter and shift registers.

Test Plan:
- WIDTH=DIGIT=1: all 8 {X,Y,CARRY_IN} combinations → SUM/CARRY_OUT match the full-adder truth table (e.g. 1,1,1 → SUM=1, CARRY_OUT=1); DONE_VALID one cycle after handshake.
- WIDTH=32, DIGIT=4: X=FFFFFFFF, Y=00000001, CARRY_IN=0 → SUM=00000000, CARRY_OUT=1, OVERFLOW=0; DONE_VALID exactly 8 cycles after handshake.
- WIDTH=32, DIGIT=4: X=7FFFFFFF, Y=00000001 → SUM=80000000, CARRY_OUT=0, OVERFLOW=1. Then X=12345678, Y=11111111, CARRY_IN=1 → SUM=2345678A, CARRY_OUT=0, OVERFLOW=0.
- Backpressure: hold DONE_READY=0 for 5 cycles after DONE_VALID → SUM/CARRY_OUT/OVERFLOW stable, START_READY=0, a START_VALID pulse is ignored. After DONE_READY=1 → IDLE, START_READY=1 the next cycle.
- Input stability: change X/Y/CARRY_IN every cycle during RUN → result equals the sum of the operands latched at the handshake.
- Reset mid-run: assert RST asynchronously at RUN step 3 → outputs 0 and START_READY=1 immediately. After release, a new X=5, Y=3 operation → SUM=8 with no residue from the aborted run.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; a single-step adder still needs one counter bit.
  function automatic int cnt_width(input int nstep);
    return (nstep <= 1) ? 1 : $clog2(nstep);
  endfunction

endpackage

// File: rtl/full_adder_chain.sv
// Combinational ripple of DIGIT full-adder cells; also exposes the carry into the top cell.
module full_adder_chain #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             CI,
  output logic [DIGIT-1:0] S,
  output logic             CO,
  output logic             C_MSB
);

  logic [DIGIT:0] c;

  assign c[0] = CI;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    assign S[gi]   = A[gi] ^ B[gi] ^ c[gi];
    assign c[gi+1] = (A[gi] & B[gi]) | (c[gi] & (A[gi] ^ B[gi]));
  end

  assign CO    = c[DIGIT];
  assign C_MSB = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit X+Y+CARRY_IN computed DIGIT bits per clock with valid/ready handshakes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CARRY_IN,
  output logic             DONE_VALID,
  input  logic             DONE_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY_OUT,
  output logic             OVERFLOW
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = cnt_width(NSTEP);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] fa_s;
  logic             fa_co;
  logic             fa_cmsb;
  logic [WIDTH-1:0] sum_shift;

  full_adder_chain #(
    .DIGIT(DIGIT)
  ) u_chain (
    .A    (x_q[DIGIT-1:0]),
    .B    (y_q[DIGIT-1:0]),
    .CI   (carry_q),
    .S    (fa_s),
    .CO   (fa_co),
    .C_MSB(fa_cmsb)
  );

  // New digits enter at the top so the LSB digit lands at bit 0 after NSTEP shifts.
  if (WIDTH == DIGIT) begin : g_single
    assign sum_shift = fa_s;
  end else begin : g_multi
    assign sum_shift = {fa_s, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (START_VALID) begin
          x_d     = X;
          y_d     = Y;
          carry_d = CARRY_IN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_shift;
        x_d     = x_q >> DIGIT;
        y_d     = y_q >> DIGIT;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          cout_d  = fa_co;
          ovf_d   = fa_co ^ fa_cmsb;
          state_d = DONE;
        end
      end
      DONE: begin
        if (DONE_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign START_READY = (state_q == IDLE);
  assign DONE_VALID  = (state_q == DONE);
  assign SUM         = sum_q;
  assign CARRY_OUT   = cout_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a 32/4 instance and a 1/1 instance checked against plain arithmetic.
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  // 32-bit, 4-bit digit instance
  logic        sv32 = 1'b0, dr32 = 1'b0, cin32 = 1'b0;
  logic [31:0] x32 = '0, y32 = '0;
  logic        sr32, dv32, cout32, ovf32;
  logic [31:0] sum32;

  // 1-bit instance
  logic        sv1 = 1'b0, dr1 = 1'b0, cin1 = 1'b0;
  logic [0:0]  x1 = '0, y1 = '0;
  logic        sr1, dv1, cout1, ovf1;
  logic [0:0]  sum1;

  int checks   = 0;
  int failures = 0;

  exp_t q32[$];
  exp_t q1[$];

  always #5 CLK = ~CLK;

  serial_adder #(.WIDTH(32), .DIGIT(4)) dut32 (
    .CLK(CLK), .RST(RST), .START_VALID(sv32), .START_READY(sr32),
    .X(x32), .Y(y32), .CARRY_IN(cin32), .DONE_VALID(dv32), .DONE_READY(dr32),
    .SUM(sum32), .CARRY_OUT(cout32), .OVERFLOW(ovf32)
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .START_VALID(sv1), .START_READY(sr1),
    .X(x1), .Y(y1), .CARRY_IN(cin1), .DONE_VALID(dv1), .DONE_READY(dr1),
    .SUM(sum1), .CARRY_OUT(cout1), .OVERFLOW(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: integer addition; overflow when same-signed operands give a differently signed sum.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic cin);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] mask;
    int          msb;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full   = {1'b0, x & mask} + {1'b0, y & mask} + {32'd0, cin};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    msb    = w - 1;
    e.ovf  = (x[msb] == y[msb]) && (e.sum[msb] != x[msb]);
    return e;
  endfunction

  // Monitors: compare whenever the consumer accepts a result.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && dv32 && dr32) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 32'd1, 32'd0);
      end else begin
        e = q32.pop_front();
        chk("sum32", sum32, e.sum);
        chk("cout32", {31'd0, cout32}, {31'd0, e.cout});
        chk("ovf32", {31'd0, ovf32}, {31'd0, e.ovf});
        $display("TXN w32 sum=%h cout=%0d ovf=%0d", sum32, cout32, ovf32);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST && dv1 && dr1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("sum1", {31'd0, sum1}, e.sum);
        chk("cout1", {31'd0, cout1}, {31'd0, e.cout});
        chk("ovf1", {31'd0, ovf1}, {31'd0, e.ovf});
        $display("TXN w1 sum=%0d cout=%0d ovf=%0d", sum1, cout1, ovf1);
      end
    end
  end

  // Issue one operation on the 32-bit instance; hold = cycles of DONE backpressure.
  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic cin, input int hold);
    int          n;
    logic [31:0] s_hold;
    logic        c_hold, o_hold;
    n = 0;
    while (!sr32 && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("start_ready_wait32", {31'd0, sr32}, 32'd1);
    x32 = x; y32 = y; cin32 = cin; sv32 = 1'b1; dr32 = (hold == 0);
    q32.push_back(model(32, x, y, cin));
    @(posedge CLK); #1;
    sv32 = 1'b0;
    n = 0;
    while (!dv32 && n < 100) begin
      chk("start_ready_run32", {31'd0, sr32}, 32'd0);
      x32 = $urandom; y32 = $urandom; cin32 = 1'($urandom); sv32 = 1'($urandom);
      @(posedge CLK); #1; n++;
    end
    sv32 = 1'b0;
    chk("latency32", n, 32'd8);
    if (hold > 0) begin
      s_hold = sum32; c_hold = cout32; o_hold = ovf32;
      for (int i = 0; i < hold; i++) begin
        sv32 = (i == 0);
        @(posedge CLK); #1;
        chk("bp_valid32", {31'd0, dv32}, 32'd1);
        chk("bp_ready32", {31'd0, sr32}, 32'd0);
        chk("bp_sum32", sum32, s_hold);
        chk("bp_cout_ovf32", {30'd0, cout32, ovf32}, {30'd0, c_hold, o_hold});
      end
      sv32 = 1'b0;
      dr32 = 1'b1;
    end
    @(posedge CLK); #1;
    dr32 = 1'b0;
    chk("idle_ready32", {31'd0, sr32}, 32'd1);
    chk("idle_valid32", {31'd0, dv32}, 32'd0);
  endtask

  task automatic run1(input logic x, input logic y, input logic cin);
    int n;
    n = 0;
    while (!sr1 && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("start_ready_wait1", {31'd0, sr1}, 32'd1);
    x1 = x; y1 = y; cin1 = cin; sv1 = 1'b1; dr1 = 1'b1;
    q1.push_back(model(1, {31'd0, x}, {31'd0, y}, cin));
    @(posedge CLK); #1;
    sv1 = 1'b0;
    n = 0;
    while (!dv1 && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("latency1", n, 32'd1);
    @(posedge CLK); #1;
    dr1 = 1'b0;
    chk("idle_ready1", {31'd0, sr1}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_sum", sum32, 32'd0);
    chk("rst_flags", {29'd0, cout32, ovf32, dv32}, 32'd0);
    chk("rst_start_ready", {30'd0, sr32, sr1}, 32'd3);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run1(i[2], i[1], i[0]);
    end

    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run32(32'h1234_5678, 32'h1111_1111, 1'b1, 5);

    // Abort at RUN step 3 with an asynchronous reset.
    x32 = 32'hDEAD_BEEF; y32 = 32'h0BAD_F00D; cin32 = 1'b1; sv32 = 1'b1;
    @(posedge CLK); #1;
    sv32 = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_sum", sum32, 32'd0);
    chk("abort_flags", {29'd0, cout32, ovf32, dv32}, 32'd0);
    chk("abort_start_ready", {31'd0, sr32}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    run32(32'd5, 32'd3, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      run32($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 6; i++) begin
      run1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge CLK);
    chk("queue32_empty", q32.size(), 32'd0);
    chk("queue1_empty", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
